apb_mem_completer: RTL and testbench

APB_MEM_COMPLETER -- requirements
Module: apb_mem_completer

---
 rtl/apb_mem_completer.sv | 201 ++++++++++++++++++++
 tb/tb_apb_mem_completer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_completer.sv
`default_nettype none
// ============================================================================
// Module   : apb_mem_completer
// Purpose  : APB completer backed by a small word memory. The setup phase is
//            captured into registers and the transfer completes from those
//            captured values after WAIT_STATES extra access cycles. Unaligned,
//            out-of-range and (optionally) protection-violating accesses
//            answer with pslverr and leave memory untouched.
// Config   : define APB_COMPLETER_PROT_EN to enable the region/pprot check.
// Ports    : pclk_i     rising-edge clock
//            reset_i    synchronous active-high reset (also clears memory)
//            psel_i, penable_i, pwrite_i, paddr_i, pprot_i, pwdata_i, pstrb_i
//                       APB requester inputs
//            prdata_o, pready_o, pslverr_o
//                       registered APB completer outputs
// Revision : 1.0 - initial release
// ============================================================================
module apb_mem_completer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                    pclk_i,
  input  logic                    reset_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic [2:0]              pprot_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o
);

  localparam int         STRB_WIDTH = DATA_WIDTH / 8;
  localparam int         IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [3:0] WAIT_CNT   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                  state_q,   state_d;
  logic [3:0]              cnt_q,     cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic                    write_q,   write_d;
  logic [2:0]              prot_q,    prot_d;
  logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
  logic [STRB_WIDTH-1:0]   strb_q,    strb_d;
  logic                    pready_q,  pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q,  prdata_d;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                    w_capture;
  logic                    w_mem_we;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_unaligned;
  logic                    w_range_err;
  logic                    w_prot_err;
  logic                    w_err;
  logic                    unused_bits;

  // All error decoding works on the captured setup, never on live inputs.
  assign w_idx       = addr_q[IDX_W+1:2];
  assign w_unaligned = |addr_q[1:0];
  assign w_range_err = |addr_q[ADDR_WIDTH-4:IDX_W+2];

`ifdef APB_COMPLETER_PROT_EN
  // Each region bit demands the matching pprot attribute.
  assign w_prot_err  = |(addr_q[ADDR_WIDTH-1:ADDR_WIDTH-3] & ~prot_q);
`else
  assign w_prot_err  = 1'b0;
`endif

  assign w_err = w_unaligned | w_range_err | w_prot_err;

  // Region bits and pprot only feed the optional protection check.
  assign unused_bits = ^{prot_q, addr_q[ADDR_WIDTH-1:ADDR_WIDTH-3]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    prot_d    = prot_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    w_mem_we  = 1'b0;
    w_capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (psel_i && !penable_i) begin
          w_capture = 1'b1;
        end else if (psel_i) begin
          // Access phase with no preceding setup.
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end
      end
      S_ACCESS: begin
        if (!psel_i) begin
          // Requester abandoned the transfer.
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else if (!penable_i) begin
          w_capture = 1'b1;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d  = S_RESP;
          pready_d = 1'b1;
          if (w_err) begin
            pslverr_d = 1'b1;
          end else if (write_q) begin
            w_mem_we = 1'b1;
          end else begin
            prdata_d = mem_q[w_idx];
          end
        end
      end
      S_RESP: begin
        if (psel_i && !penable_i) begin
          w_capture = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_capture) begin
      state_d = S_ACCESS;
      cnt_d   = WAIT_CNT;
      addr_d  = paddr_i;
      write_d = pwrite_i;
      prot_d  = pprot_i;
      wdata_d = pwdata_i;
      strb_d  = pstrb_i;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      prot_q    <= 3'd0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      prot_q    <= prot_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Reset wins over a same-edge write, so an aborted transfer never lands.
  always_ff @(posedge pclk_i) begin
    if (reset_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (strb_q[b]) begin
          mem_q[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_completer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_mem_completer
// Purpose  : Self-checking bench for apb_mem_completer. The driver issues APB
//            transfers and pushes the expected response into a queue computed
//            from a word-array reference model; a negedge monitor pops and
//            compares whenever pready is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_mem_completer;

  localparam int WS = 1;
`ifdef APB_COMPLETER_PROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [2:0]  pprot = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [64];

  apb_mem_completer #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (64),
    .WAIT_STATES(WS)
  ) dut (
    .pclk_i   (pclk),
    .reset_i  (reset),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .paddr_i  (paddr),
    .pprot_i  (pprot),
    .pwdata_i (pwdata),
    .pstrb_i  (pstrb),
    .prdata_o (prdata_o),
    .pready_o (pready_o),
    .pslverr_o(pslverr_o)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_err(input logic [31:0] a, input logic [2:0] p);
    bit e;
    e = (a % 4 != 0) || ((a >> 8) % (1 << 21) != 0);
    if (PROT_EN && ((a[31:29] & ~p) != 3'd0)) e = 1'b1;
    return e;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
  endfunction

  // Issue-time bookkeeping: update model and record the expected response.
  function automatic void expect_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, input logic [2:0] p);
    exp_t e;
    int   w;
    w      = int'((a >> 2) % 64);
    e.err  = model_err(a, p);
    e.data = '0;
    if (!e.err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
      end else begin
        e.data = ref_mem[w];
      end
    end
    exp_q.push_back(e);
  endfunction

  function automatic void expect_err();
    exp_t e;
    e.err  = 1'b1;
    e.data = '0;
    exp_q.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge pclk) begin
    if (!reset) begin
      if (pready_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pready actual=1 required=0");
        end else begin
          mon_e = exp_q.pop_front();
          chk("pslverr", 64'(pslverr_o), 64'(mon_e.err));
          chk("prdata", 64'(prdata_o), 64'(mon_e.data));
        end
      end else begin
        chk("idle_outputs_zero", 64'({pslverr_o, prdata_o}), 64'(0));
      end
    end
  end

  // ---------------- driver tasks (all start/end at posedge+1) ----------------
  task automatic idle_cycle();
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_pready", 64'(pready_o), 64'(0));
    chk("reset_pslverr", 64'(pslverr_o), 64'(0));
    chk("reset_prdata", 64'(prdata_o), 64'(0));
    reset = 1'b0;
    exp_q.delete();
    model_clear();
  endtask

  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p, input bit b2b);
    int n;
    expect_xfer(wr, a, d, s, p);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = p;
    @(posedge pclk); #1;
    penable = 1'b1;
    // Completion must come from the captured setup, so disturb the live bus.
    paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom); pprot = 3'($urandom);
    pwrite = 1'($urandom);
    n = 0;
    do begin
      @(posedge pclk); #1;
      n++;
    end while (!pready_o && n < 20);
    chk("latency", 64'(n), 64'(WS + 1));
    if (!b2b) idle_cycle();
  endtask

  task automatic early_deassert(input logic [31:0] a);
    expect_err();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = $urandom; pstrb = 4'hF;
    pprot = 3'b111;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    chk("early_pready", 64'(pready_o), 64'(1));
    idle_cycle();
  endtask

  task automatic no_setup(input logic [31:0] a);
    expect_err();
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = $urandom; pstrb = 4'hF;
    pprot = 3'b111;
    @(posedge pclk); #1;
    chk("nosetup_pready", 64'(pready_o), 64'(1));
    idle_cycle();
  endtask

  task automatic junk_setup();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = $urandom % 256 & 32'hFC;
    pwdata = $urandom; pstrb = 4'hF; pprot = 3'b111;
    @(posedge pclk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int          r;
    if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, 15)) * 4;
    else                           a = 32'($urandom_range(0, 63)) * 4;
    r = $urandom_range(0, 9);
    if (r == 0)      a = a + 32'($urandom_range(1, 3));
    else if (r == 1) a = a | (32'd1 << (8 + $urandom_range(0, 20)));
    if ($urandom_range(0, 3) == 0) a[31:29] = 3'($urandom);
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit          pend;
    bit          b2b;
    int          op;
    logic [31:0] a;
    pend = 1'b0;
    model_clear();
    reset_dut();

    // Read after reset, write/read back full word.
    xfer(1'b0, 32'h4, 32'h0, 4'hF, 3'b000, 1'b0);
    xfer(1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, 3'b000, 1'b0);
    xfer(1'b0, 32'h4, 32'h0, 4'hF, 3'b000, 1'b0);

    // Single byte lane write.
    reset_dut();
    xfer(1'b1, 32'h84, 32'hFFFF_FFFF, 4'h1, 3'b000, 1'b0);
    xfer(1'b0, 32'h84, 32'h0, 4'h0, 3'b000, 1'b0);

    // Unaligned read, abandoned write, then target word unchanged.
    xfer(1'b0, 32'h3, 32'h0, 4'hF, 3'b000, 1'b0);
    xfer(1'b1, 32'h10, 32'h1234_5678, 4'hF, 3'b000, 1'b0);
    early_deassert(32'h10);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 1'b0);

    // Region/protection cases.
    xfer(1'b0, 32'hE000_0004, 32'h0, 4'hF, 3'b111, 1'b0);
    xfer(1'b0, 32'hE000_0004, 32'h0, 4'hF, 3'b110, 1'b0);
    xfer(1'b0, 32'hE000_0004, 32'h0, 4'hF, 3'b101, 1'b0);
    xfer(1'b0, 32'hE000_0004, 32'h0, 4'hF, 3'b011, 1'b0);

    // Back-to-back chain, zero-strobe write, access without setup, re-setup.
    xfer(1'b1, 32'h20, 32'hA5A5_5A5A, 4'hF, 3'b000, 1'b1);
    xfer(1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 3'b000, 1'b1);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, 3'b000, 1'b1);
    xfer(1'b0, 32'h4, 32'h0, 4'hF, 3'b000, 1'b0);
    no_setup(32'h8);
    junk_setup();
    xfer(1'b0, 32'h20, 32'h0, 4'hF, 3'b000, 1'b0);

    // Reset on the completing edge of a write aborts it.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'hDEAD_BEEF;
    pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    reset = 1'b1;
    @(posedge pclk); #1;
    chk("midrst_pready", 64'(pready_o), 64'(0));
    chk("midrst_pslverr", 64'(pslverr_o), 64'(0));
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    model_clear();
    exp_q.delete();
    idle_cycle();
    xfer(1'b0, 32'h30, 32'h0, 4'hF, 3'b000, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      op = $urandom_range(0, 19);
      a  = rand_addr();
      if (op >= 3) begin
        b2b = 1'($urandom);
        xfer(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom), b2b);
        pend = b2b;
      end else begin
        if (pend) idle_cycle();
        pend = 1'b0;
        case (op)
          0:       early_deassert(a);
          1:       no_setup(a);
          default: begin
            junk_setup();
            xfer(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom), 1'b0);
          end
        endcase
      end
    end
    if (pend) idle_cycle();

    repeat (3) @(posedge pclk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
